// File: rtl/jg3_pkg.sv
// Shared types and helpers for the JG3 run monitor: FSM state encoding,
// sample classification of the range-judge X/Y flags.
package jg3_pkg;

  localparam int RUN_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    ALARM = 2'd2,
    FAULT = 2'd3
  } jg3_mon_state_t;

  typedef enum logic [1:0] {
    CLS_MID  = 2'd0,
    CLS_HIGH = 2'd1,
    CLS_ZERO = 2'd2,
    CLS_BAD  = 2'd3
  } jg3_sample_class_t;

  // X and Y together cannot come from a healthy JG3, so that pair is BAD
  function automatic jg3_sample_class_t classify(input logic x, input logic y);
    jg3_sample_class_t cls;
    cls = CLS_MID;
    if (x && y)  cls = CLS_BAD;
    else if (x)  cls = CLS_HIGH;
    else if (y)  cls = CLS_ZERO;
    return cls;
  endfunction

endpackage

// File: rtl/jg3_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module jg3_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (inc && (count != {W{1'b1}}))
      count <= count + W'(1);
  end

endmodule

// File: rtl/jg3_run_monitor.sv
// Run monitor for JG3 flags: counts consecutive HIGH samples into a latched
// alarm, tracks a sticky zero flag, a saturating HIGH total and BAD faults.
module jg3_run_monitor
  import jg3_pkg::*;
#(
  parameter int HIGH_RUN = 3,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_valid,
  input  logic             x_in,
  input  logic             y_in,
  input  logic             ack,
  output logic             alarm,
  output logic             fault,
  output logic             zero_seen,
  output logic [CNT_W-1:0] high_total,
  output logic [1:0]       state
);

  localparam logic [RUN_W-1:0] RUN_TARGET = RUN_W'(HIGH_RUN);

  jg3_mon_state_t    cur_state, nxt_state;
  jg3_sample_class_t cls;
  logic [RUN_W-1:0]  run, nxt_run, run_inc;
  logic              is_high, is_zero, is_mid, is_bad;

  assign cls     = classify(x_in, y_in);
  assign is_high = sample_valid && (cls == CLS_HIGH);
  assign is_zero = sample_valid && (cls == CLS_ZERO);
  assign is_mid  = sample_valid && (cls == CLS_MID);
  assign is_bad  = sample_valid && (cls == CLS_BAD);
  assign run_inc = run + RUN_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= IDLE;
      run       <= '0;
    end else begin
      cur_state <= nxt_state;
      run       <= nxt_run;
    end
  end

  // ack only matters for leaving ALARM/FAULT; in IDLE/RUN samples proceed as usual
  always_comb begin
    nxt_state = cur_state;
    nxt_run   = run;
    if (is_bad) begin
      nxt_state = FAULT;
      nxt_run   = '0;
    end else begin
      case (cur_state)
        IDLE: begin
          if (is_high) begin
            nxt_run   = RUN_W'(1);
            nxt_state = (RUN_TARGET == RUN_W'(1)) ? ALARM : RUN;
          end else if (is_mid || is_zero) begin
            nxt_run = '0;
          end
        end
        RUN: begin
          if (is_high) begin
            nxt_run = run_inc;
            if (run_inc == RUN_TARGET) nxt_state = ALARM;
          end else if (is_mid || is_zero) begin
            nxt_state = IDLE;
            nxt_run   = '0;
          end
        end
        ALARM, FAULT: begin
          if (ack) begin
            nxt_state = IDLE;
            nxt_run   = '0;
          end
        end
        default: begin
          nxt_state = IDLE;
          nxt_run   = '0;
        end
      endcase
    end
  end

  always_comb begin
    alarm = (cur_state == ALARM);
    fault = (cur_state == FAULT);
    state = cur_state;
  end

  // A ZERO sample wins over a simultaneous ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      zero_seen <= 1'b0;
    else if (is_zero)
      zero_seen <= 1'b1;
    else if (ack)
      zero_seen <= 1'b0;
  end

  jg3_sat_counter #(.W(CNT_W)) u_high_total (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (is_high),
    .clr   (1'b0),
    .count (high_total)
  );

endmodule

// File: doc/jg3_run_monitor.md
# jg3_run_monitor

Sequential consumer of the JG3 range-judge flags. Each strobed sample carries X (code ≥ 5) and Y (code == 0). The block counts consecutive high samples and raises a latched alarm after a programmable run length. It also keeps a sticky zero-seen flag and a saturating total of high samples. It flags the illegal X&Y combination as a fault.

## Interface
- HIGH_RUN, default 3: consecutive valid high samples needed to raise the alarm; legal range 1..255.
- CNT_W, default 8: width of the total high-sample counter.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous active-low reset.
- sample_valid  input  1  one-cycle strobe; X/Y are sampled only when high.
- x_in  input  1  JG3 X flag (code ≥ 5).
- y_in  input  1  JG3 Y flag (code == 0).
- ack  input  1  level; clears the alarm, fault and zero_seen.
- alarm  output  1  high while state == ALARM.
- fault  output  1  high while state == FAULT.
- zero_seen  output  1  sticky; a valid zero sample has occurred since the last ack/reset.
- high_total  output  CNT_W  saturating count of valid high samples.
- state  output  2  current FSM state.

## Operation
- Sample classes, qualified by sample_valid:
  - HIGH: x_in=1, y_in=0.
  - ZERO: x_in=0, y_in=1.
  - MID: x_in=0, y_in=0.
  - BAD: x_in=1, y_in=1 (never produced by JG3).
- FSM state encodings: IDLE=2'd0, RUN=2'd1, ALARM=2'd2, FAULT=2'd3.
- Internal run counter is 8 bits wide.
- Priority per cycle: BAD > ack > sample class.
- IDLE:
  - HIGH: run=1; go to ALARM if HIGH_RUN==1, else RUN.
  - MID or ZERO: stay; run=0.
- RUN:
  - HIGH: run+1; on reaching HIGH_RUN go to ALARM.
  - MID or ZERO: go to IDLE; run=0.
  - No valid sample: hold.
- ALARM:
  - Held until ack; ack gives IDLE with run=0.
  - Samples still update high_total and zero_seen; run does not change.
- FAULT:
  - Entered from any state on BAD; run=0.
  - Left only on ack, to IDLE.
  - BAD together with ack keeps or enters FAULT.
- zero_seen: set on a valid ZERO sample; cleared by ack. Set and clear in the same cycle gives set.
- high_total: +1 on each valid HIGH sample in any state, including ALARM and FAULT. Saturates at 2^CNT_W−1 with no wrap. Cleared only by reset.
- ack in IDLE or RUN clears zero_seen only; the RUN count is unaffected.

## Timing
- All outputs are registered and change on the clk edge after the qualifying input cycle: one-cycle latency.
- Reset values, asserted asynchronously and released synchronously by the designer's reset tree: state=IDLE, run=0, alarm=0, fault=0, zero_seen=0, high_total=0.
- Reset mid-run or mid-alarm discards all history immediately; there is no pending alarm after reset.
- alarm is high from the cycle after the HIGH_RUN-th consecutive HIGH sample.
  - Minimum alarm pulse is one cycle, when ack is already high.
- Gaps (sample_valid=0) between HIGH samples do not break a run; only MID, ZERO or BAD samples break it.
- ack is level sensitive; holding it high keeps the block in IDLE/RUN behaviour apart from BAD handling.

## Structure
- Shared package jg3_pkg:
  - State enum typedef jg3_mon_state_t with the encodings above.
  - Sample-class enum (HIGH/ZERO/MID/BAD).
  - Function classify(x,y) returning the class.
- Sub-module jg3_sat_counter (parameter W; inc, clr, count): used for high_total.
- The run counter and FSM stay in the top module, jg3_run_monitor.

## Test plan
- Reset, then three valid HIGH samples on consecutive cycles (HIGH_RUN=3):
  - alarm=1 and state=2 on the edge after the third sample.
  - high_total=3.
- HIGH, HIGH, MID, HIGH, HIGH:
  - alarm stays 0 and state returns to IDLE after the MID.
  - high_total=4.
- BAD sample while in RUN:
  - fault=1 and state=3 next cycle.
  - BAD+ack in the same cycle keeps fault=1.
  - Plain ack then returns to state=0.
- ZERO sample, then ack and ZERO in the same cycle:
  - zero_seen=1 after the first sample and stays 1 after the second cycle.
  - ack alone clears it to 0.
- CNT_W=3, ten HIGH samples:
  - high_total saturates at 7 without wrap.
  - alarm remains 1 until ack.
- Assert rst_n=0 asynchronously while in ALARM with high_total=5:
  - All outputs go to 0 immediately, without waiting for a clk edge.
  - After release, a single HIGH sample gives state=RUN, not ALARM.
